// File: rtl/retry_inorder_end.sv
// In-order end stage of the time-redundant retry chain: bounces failed results back
// upstream as retry requests and releases good results strictly in id order.
module retry_inorder_end #(
    parameter type DataType = logic,
    parameter int  IDSize   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$bits(DataType)-1:0]  data_i,
    input  logic [IDSize-1:0]           id_i,
    input  logic                        needs_retry_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [$bits(DataType)-1:0]  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [IDSize-1:0]           retry_id_o,
    output logic                        retry_valid_o,
    input  logic                        retry_ready_i,
    output logic [IDSize:0]             fill_o,
    output logic                        dup_o
);

    localparam int Depth = 2 ** IDSize;
    localparam logic [IDSize-1:0] HeadOne = 1;
    localparam logic [IDSize:0]   FillOne = 1;

    logic [$bits(DataType)-1:0] store_q [Depth];
    logic [Depth-1:0]           full_q;
    logic [IDSize-1:0]          head_q;
    logic                       retry_pending_q;
    logic [IDSize-1:0]          retry_id_q;
    logic [IDSize:0]            fill_q;
    logic                       dup_q;

    logic in_fire;
    logic retry_fire;
    logic good_fire;
    logic write_en;
    logic dup_hit;
    logic release_fire;

    // A pending retry blocks the input only while the retry start cannot take it.
    assign ready_o      = !retry_pending_q || retry_ready_i;
    assign in_fire      = valid_i && ready_o;
    assign retry_fire   = in_fire && needs_retry_i;
    assign good_fire    = in_fire && !needs_retry_i;
    assign write_en     = good_fire && !full_q[id_i];
    assign dup_hit      = good_fire && full_q[id_i];

    assign valid_o       = full_q[head_q];
    assign data_o        = store_q[head_q];
    assign release_fire  = valid_o && ready_i;
    assign retry_valid_o = retry_pending_q;
    assign retry_id_o    = retry_id_q;
    assign fill_o        = fill_q;
    assign dup_o         = dup_q;

    // A write can never target head while it releases: a full head turns it into a duplicate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q          <= '0;
            head_q          <= '0;
            retry_pending_q <= 1'b0;
            fill_q          <= '0;
            dup_q           <= 1'b0;
        end else begin
            if (release_fire) begin
                full_q[head_q] <= 1'b0;
                head_q         <= head_q + HeadOne;
            end
            if (write_en) begin
                full_q[id_i] <= 1'b1;
            end
            if (write_en && !release_fire) begin
                fill_q <= fill_q + FillOne;
            end else if (!write_en && release_fire) begin
                fill_q <= fill_q - FillOne;
            end
            if (retry_fire) begin
                retry_pending_q <= 1'b1;
            end else if (retry_ready_i) begin
                retry_pending_q <= 1'b0;
            end
            dup_q <= dup_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (retry_fire) begin
            retry_id_q <= id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            store_q[id_i] <= data_i;
        end
    end

endmodule

// File: doc/retry_inorder_end.md
Name: retry_inorder_end

Overview:
- Sits directly downstream of time_DMR_end in the time-redundant retry chain. It is the in-order alternative to the plain retry end stage.
- Accepts tagged results (data, id, needs_retry) and returns every needs_retry id to the upstream retry start as a retry request.
- Buffers good results in an id-indexed reorder store and releases them strictly in id order, so consumers downstream never see the reordering a retry causes.

Parameters:
- DataType, logic, payload type carried per transaction.
- IDSize, 4, id width; the store holds 2**IDSize entries, one per id.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- data_i  in  $bits(DataType)  result payload from time_DMR_end
- id_i  in  IDSize  transaction id
- needs_retry_i  in  1  result failed the DMR compare; request a retry
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  $bits(DataType)  in-order payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_o  out  IDSize  id to be re-issued upstream
- retry_valid_o  out  1  retry request valid
- retry_ready_i  in  1  retry start accepts the request
- fill_o  out  IDSize+1  number of stored entries not yet released
- dup_o  out  1  one-cycle pulse: good result dropped because its slot was already full

Behaviour:
- State:
  - store[2**IDSize] of DataType, with a per-slot full bit.
  - head pointer, IDSize bits, wraps modulo 2**IDSize.
  - retry register: pending bit plus id.
  - fill counter.
- Reset (clk_i edge with rst_i=1): all full bits 0, head=0, retry pending=0, fill=0, dup_o=0.
  - Outputs after reset: valid_o=0, retry_valid_o=0, fill_o=0.
  - Reset mid-operation discards every stored and pending entry. The upstream retry start must be reset in the same cycle.
- Input handshake:
  - ready_o = !retry_pending | retry_ready_i. This is combinational and independent of valid_i.
  - Input fires when valid_i & ready_o.
- Fire with needs_retry_i=1:
  - Next cycle retry pending=1 and retry id=id_i. data_i is discarded.
  - The store is not touched.
- Fire with needs_retry_i=0 and store.full[id_i]=0:
  - Write data_i to store[id_i], set full[id_i], increment fill.
- Fire with needs_retry_i=0 and store.full[id_i]=1:
  - Drop data_i; the stored copy wins. Pulse dup_o for one cycle. fill is unchanged.
- Retry output:
  - retry_valid_o = pending, retry_id_o = retry id register.
  - On retry_valid_o & retry_ready_i, clear pending unless a new needs_retry fire occurs in the same cycle; in that case load the new id and keep pending=1.
- Output:
  - valid_o = full[head]; data_o = store[head]. Both are combinational from registers.
  - On valid_o & ready_i: clear full[head], head <= head+1 (wrapping 15->0 for IDSize=4), decrement fill.
  - valid_o holds with stable data_o until accepted.
- Latency: minimum one cycle from input fire to valid_o, when the id equals head. There is no combinational path from data_i to data_o.
- Simultaneous events:
  - Release of head and a write to another slot in the same cycle: fill stays unchanged.
  - Write to slot head while head is releasing is impossible, because full[head]=1 makes it a duplicate.
  - Write to head when empty: visible on valid_o the next cycle.
- Window assumption: upstream issues at most 2**IDSize outstanding ids, so ids outside the window never occur and the block does not check for them.
- fill_o ranges 0..2**IDSize inclusive; width IDSize+1 covers a full store.

Test Plan:
- In-order stream, IDSize=4, ids 0..20 (wrapping through 15->0), all good, ready_i=1 -> outputs in id order 0..15,0..4 with matching data. Each output one cycle after its input; fill_o stays ≤1.
- Retry with reorder: ids 0,1(needs_retry),2,3 good, then id1 good 5 cycles later -> retry_valid_o=1 with retry_id_o=1 the cycle after id1 arrives. Output is id0, a stall with fill_o=2, then ids 1,2,3 back to back once id1 lands.
- Retry backpressure: retry_ready_i=0 while two needs_retry ids 5 then 6 arrive -> after the first, ready_o=0 and id6 is held upstream. Raising retry_ready_i accepts id5 and takes id6 in the same cycle; retry_id_o=6 the next cycle.
- Duplicate: good id 7 with data 0xAA, then good id 7 with data 0xBB before release -> dup_o pulses once, fill_o unchanged, output data 0xAA.
- Downstream stall: ready_i=0 while all 16 ids arrive -> fill_o reaches 16, valid_o steady with data_o stable for head=0. Releasing ready_i drains 16 entries in order, one per cycle.
- Reset mid-operation: assert rst_i with fill_o=5 and a retry pending -> next cycle fill_o=0, valid_o=0, retry_valid_o=0. The next id 0 is released normally.
